// File: rtl/ahb_bridge_pkg.sv
// Shared types for the AHB2AHB bridge: transfer encodings, slave FSM states
// and the packed command word carried through the async write FIFO.
package ahb_bridge_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int CMD_W      = 1 + 3 + CMD_ADDR_W + CMD_DATA_W;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PUSH_WAIT,
        ST_RD_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [2:0]            size;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/ahb_slave_fifo_push.sv
// AHB-Lite slave front-end: turns each accepted transfer into one command
// word pushed into the async write FIFO, stalling on FIFO full and holding
// read data phases until the return path answers.
module ahb_slave_fifo_push
    import ahb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CMD_W  = 1 + 3 + ADDR_W + DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hsel,
    input  logic [ADDR_W-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic [DATA_W-1:0] i_hwdata,
    input  logic              i_hready,
    output logic              o_hreadyout,
    output logic              o_hresp,
    output logic [DATA_W-1:0] o_hrdata,
    output logic              o_w_inc,
    output logic [CMD_W-1:0]  o_w_data,
    input  logic              i_w_full,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_err
);

    state_e            state_q;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] hrdata_q;

    logic ready;
    logic resp;
    logic push;
    cmd_t push_word;
    logic accept;

    // Ready/response/push decode. Kept combinational so a write data phase
    // against a non-full FIFO completes with zero wait states and the push
    // is gated by the live full flag.
    always_comb begin
        ready     = 1'b1;
        resp      = HRESP_OKAY;
        push      = 1'b0;
        push_word = '0;
        case (state_q)
            ST_DATA: begin
                push      = !i_w_full;
                ready     = cmd_q.write & !i_w_full;
                push_word = cmd_q;
                if (cmd_q.write) push_word.data = i_hwdata;
                if (!push) push_word = '0;
            end
            ST_PUSH_WAIT: begin
                push      = !i_w_full;
                ready     = cmd_q.write & !i_w_full;
                push_word = push ? cmd_q : '0;
            end
            ST_RD_WAIT: ready = 1'b0;
            ST_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            ST_ERR2: resp = HRESP_ERROR;
            default: ;
        endcase
    end

    // A new address phase is only taken while this slave is completing (or
    // not holding) a data phase, so a stalled transfer is never overwritten.
    assign accept = i_hsel & i_hready & ready &
                    ((htrans_e'(i_htrans) == HT_NONSEQ) || (htrans_e'(i_htrans) == HT_SEQ));

    // Transfer FSM plus the command holding register and read data register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            hrdata_q <= '0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (cmd_q.write) begin
                        if (i_w_full) begin
                            cmd_q.data <= i_hwdata;
                            state_q    <= ST_PUSH_WAIT;
                        end else begin
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        state_q <= i_w_full ? ST_PUSH_WAIT : ST_RD_WAIT;
                    end
                end
                ST_PUSH_WAIT: begin
                    if (!i_w_full) state_q <= cmd_q.write ? ST_IDLE : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (i_rd_valid) begin
                        if (i_rd_err) begin
                            state_q <= ST_ERR1;
                        end else begin
                            hrdata_q <= i_rd_data;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_ERR1: state_q <= ST_ERR2;
                ST_ERR2: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            // A pipelined accept overrides the return-to-idle above.
            if (accept) begin
                state_q    <= ST_DATA;
                cmd_q.write <= i_hwrite;
                cmd_q.size  <= i_hsize;
                cmd_q.addr  <= i_haddr;
                cmd_q.data  <= '0;
            end
        end
    end

    assign o_hreadyout = ready;
    assign o_hresp     = resp;
    assign o_hrdata    = hrdata_q;
    assign o_w_inc     = push;
    assign o_w_data    = push_word;

endmodule

// File: tb/tb_ahb_slave_fifo_push.sv
// Directed bench for the AHB slave FIFO push front-end.
module tb_ahb_slave_fifo_push;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_hsel;
    logic [31:0] i_haddr;
    logic [1:0]  i_htrans;
    logic        i_hwrite;
    logic [2:0]  i_hsize;
    logic [31:0] i_hwdata;
    logic        i_hready;
    logic        o_hreadyout;
    logic        o_hresp;
    logic [31:0] o_hrdata;
    logic        o_w_inc;
    logic [67:0] o_w_data;
    logic        i_w_full;
    logic        i_rd_valid;
    logic [31:0] i_rd_data;
    logic        i_rd_err;

    int checks = 0;
    int errors = 0;

    ahb_slave_fifo_push dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hsel(i_hsel), .i_haddr(i_haddr),
        .i_htrans(i_htrans), .i_hwrite(i_hwrite), .i_hsize(i_hsize),
        .i_hwdata(i_hwdata), .i_hready(i_hready), .o_hreadyout(o_hreadyout),
        .o_hresp(o_hresp), .o_hrdata(o_hrdata), .o_w_inc(o_w_inc),
        .o_w_data(o_w_data), .i_w_full(i_w_full), .i_rd_valid(i_rd_valid),
        .i_rd_data(i_rd_data), .i_rd_err(i_rd_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic addr_phase(input logic sel, input logic [1:0] trans,
                              input logic wr, input logic [31:0] addr);
        i_hsel   = sel;
        i_htrans = trans;
        i_hwrite = wr;
        i_haddr  = addr;
        i_hsize  = 3'b010;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", o_hreadyout); end
        checks++; if (o_hresp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %0b want 0", o_hresp); end
        checks++; if (o_hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h want 0", o_hrdata); end
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL rst_inc: got %0b want 0", o_w_inc); end
        checks++; if (o_w_data !== 68'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", o_w_data); end
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_idle_busy();
        step(); addr_phase(1'b1, 2'b01, 1'b1, 32'h500);
        step(); addr_phase(1'b0, 2'b10, 1'b1, 32'h504);
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL busy_inc: got %0b want 0", o_w_inc); end
        step(); addr_phase(1'b1, 2'b00, 1'b1, 32'h508);
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL unsel_inc: got %0b want 0", o_w_inc); end
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL unsel_ready: got %0b want 1", o_hreadyout); end
        step();
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL idle_inc: got %0b want 0", o_w_inc); end
    endtask

    task automatic test_single_write();
        step(); addr_phase(1'b1, 2'b10, 1'b1, 32'h1000_0004);
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL wr_addr_inc: got %0b want 0", o_w_inc); end
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0); i_hwdata = 32'hDEAD_BEEF;
        #3;
        checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL wr_inc: got %0b want 1", o_w_inc); end
        checks++; if (o_w_data !== {1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_data: got %h want %h", o_w_data, {1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF}); end
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b want 1", o_hreadyout); end
        step();
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL wr_after_inc: got %0b want 0", o_w_inc); end
    endtask

    task automatic test_back_to_back();
        logic [67:0] exp;
        step(); addr_phase(1'b1, 2'b10, 1'b1, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            i_hwdata = 32'hA0 + 32'(i);
            if (i < 3) addr_phase(1'b1, 2'b11, 1'b1, 32'h104 + 32'(4 * i));
            else       addr_phase(1'b0, 2'b00, 1'b0, 32'h0);
            #3;
            exp = {1'b1, 3'b010, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)};
            checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL b2b_inc[%0d]: got %0b want 1", i, o_w_inc); end
            checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, o_hreadyout); end
            checks++; if (o_w_data !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_w_data, exp); end
        end
        step();
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL b2b_end_inc: got %0b want 0", o_w_inc); end
    endtask

    task automatic test_write_full();
        step(); addr_phase(1'b1, 2'b10, 1'b1, 32'h200); i_w_full = 1'b1;
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0); i_hwdata = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin step(); i_hwdata = 32'h0; end
            #3;
            checks++; if (o_hreadyout !== 1'b0) begin errors++; $display("FAIL full_ready[%0d]: got %0b want 0", k, o_hreadyout); end
            checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL full_inc[%0d]: got %0b want 0", k, o_w_inc); end
        end
        step(); i_w_full = 1'b0;
        #3;
        checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL full_push_inc: got %0b want 1", o_w_inc); end
        checks++; if (o_w_data !== {1'b1, 3'b010, 32'h200, 32'hCAFE_F00D}) begin errors++; $display("FAIL full_push_data: got %h want %h", o_w_data, {1'b1, 3'b010, 32'h200, 32'hCAFE_F00D}); end
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL full_push_ready: got %0b want 1", o_hreadyout); end
        step();
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL full_after_inc: got %0b want 0", o_w_inc); end
    endtask

    task automatic test_read();
        step(); i_rd_valid = 1'b1; i_rd_data = 32'h5555_5555;
        step(); i_rd_valid = 1'b0;
        #3;
        checks++; if (o_hrdata !== 32'h0) begin errors++; $display("FAIL rd_ignored: got %h want 0", o_hrdata); end
        step(); addr_phase(1'b1, 2'b10, 1'b0, 32'h20);
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0);
        #3;
        checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL rd_push_inc: got %0b want 1", o_w_inc); end
        checks++; if (o_w_data !== {1'b0, 3'b010, 32'h20, 32'h0}) begin errors++; $display("FAIL rd_push_data: got %h want %h", o_w_data, {1'b0, 3'b010, 32'h20, 32'h0}); end
        checks++; if (o_hreadyout !== 1'b0) begin errors++; $display("FAIL rd_push_ready: got %0b want 0", o_hreadyout); end
        for (int k = 1; k <= 4; k++) begin
            step();
            #3;
            checks++; if (o_hreadyout !== 1'b0 || o_w_inc !== 1'b0) begin errors++; $display("FAIL rd_wait[%0d]: got ready %0b inc %0b want 0 0", k, o_hreadyout, o_w_inc); end
        end
        step(); i_rd_valid = 1'b1; i_rd_data = 32'h1234_5678; i_rd_err = 1'b0;
        #3;
        checks++; if (o_hreadyout !== 1'b0) begin errors++; $display("FAIL rd_valid_ready: got %0b want 0", o_hreadyout); end
        step(); i_rd_valid = 1'b0; i_rd_data = 32'h0;
        #3;
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL rd_done_ready: got %0b want 1", o_hreadyout); end
        checks++; if (o_hrdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_done_data: got %h want 12345678", o_hrdata); end
        checks++; if (o_hresp !== 1'b0) begin errors++; $display("FAIL rd_done_resp: got %0b want 0", o_hresp); end
    endtask

    task automatic test_read_err();
        step(); addr_phase(1'b1, 2'b10, 1'b0, 32'h40);
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0);
        #3;
        checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL err_push_inc: got %0b want 1", o_w_inc); end
        step(); i_rd_valid = 1'b1; i_rd_err = 1'b1; i_rd_data = 32'hFFFF_FFFF;
        step(); i_rd_valid = 1'b0; i_rd_err = 1'b0; i_rd_data = 32'h0;
        #3;
        checks++; if (o_hresp !== 1'b1 || o_hreadyout !== 1'b0) begin errors++; $display("FAIL err1: got resp %0b ready %0b want 1 0", o_hresp, o_hreadyout); end
        step();
        #3;
        checks++; if (o_hresp !== 1'b1 || o_hreadyout !== 1'b1) begin errors++; $display("FAIL err2: got resp %0b ready %0b want 1 1", o_hresp, o_hreadyout); end
        step();
        #3;
        checks++; if (o_hresp !== 1'b0 || o_hreadyout !== 1'b1) begin errors++; $display("FAIL err_idle: got resp %0b ready %0b want 0 1", o_hresp, o_hreadyout); end
        checks++; if (o_hrdata !== 32'h1234_5678) begin errors++; $display("FAIL err_hrdata_hold: got %h want 12345678", o_hrdata); end
    endtask

    task automatic test_reset_mid();
        step(); addr_phase(1'b1, 2'b10, 1'b1, 32'h300); i_w_full = 1'b1;
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0); i_hwdata = 32'h77;
        step();
        #1; i_rst = 1'b1; i_w_full = 1'b0;
        #1;
        checks++; if (o_hreadyout !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b want 1", o_hreadyout); end
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL mid_rst_inc: got %0b want 0", o_w_inc); end
        checks++; if (o_w_data !== 68'h0) begin errors++; $display("FAIL mid_rst_wdata: got %h want 0", o_w_data); end
        checks++; if (o_hrdata !== 32'h0) begin errors++; $display("FAIL mid_rst_hrdata: got %h want 0", o_hrdata); end
        step(); step(); i_rst = 1'b0;
        step();
        #3;
        checks++; if (o_w_inc !== 1'b0) begin errors++; $display("FAIL post_rst_inc: got %0b want 0", o_w_inc); end
        step(); addr_phase(1'b1, 2'b10, 1'b1, 32'h400);
        step(); addr_phase(1'b0, 2'b00, 1'b0, 32'h0); i_hwdata = 32'h4444;
        #3;
        checks++; if (o_w_inc !== 1'b1) begin errors++; $display("FAIL post_rst_wr_inc: got %0b want 1", o_w_inc); end
        checks++; if (o_w_data !== {1'b1, 3'b010, 32'h400, 32'h4444}) begin errors++; $display("FAIL post_rst_wr_data: got %h want %h", o_w_data, {1'b1, 3'b010, 32'h400, 32'h4444}); end
    endtask

    initial begin
        i_rst = 1'b1; i_hsel = 1'b0; i_haddr = '0; i_htrans = 2'b00; i_hwrite = 1'b0;
        i_hsize = 3'b010; i_hwdata = '0; i_hready = 1'b1; i_w_full = 1'b0;
        i_rd_valid = 1'b0; i_rd_data = '0; i_rd_err = 1'b0;
        test_reset();
        test_idle_busy();
        test_single_write();
        test_back_to_back();
        test_write_full();
        test_read();
        test_read_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
